// File: rtl/switch_debounce.sv
// Two-flop synchroniser plus per-bit stability counter for board switches.
// Outputs a clean switch vector, per-bit change pulses and a settle flag.
module switch_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] switch_raw,
    output logic [WIDTH-1:0] switch_stable,
    output logic [WIDTH-1:0] switch_changed,
    output logic             switch_ready
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 3);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] READY_AT  = CW'(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] START_SAT = CW'(DEBOUNCE_CYCLES + 2);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CW-1:0]    cnt [WIDTH];
    logic [CW-1:0]    startup_cnt;
    logic [WIDTH-1:0] differ;
    logic [WIDTH-1:0] flip;

    always_comb begin
        differ = sync2 ^ switch_stable;
        flip   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            flip[i] = differ[i] && (cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1          <= '0;
            sync2          <= '0;
            switch_stable  <= '0;
            switch_changed <= '0;
            switch_ready   <= 1'b0;
            startup_cnt    <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= switch_raw;
            sync2 <= sync1;
            // A matching sample or an accepted change both restart the window.
            for (int i = 0; i < WIDTH; i++) begin
                if (!differ[i] || flip[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
            switch_stable  <= switch_stable ^ flip;
            switch_changed <= flip & {WIDTH{switch_ready}};
            if (startup_cnt != START_SAT) begin
                startup_cnt <= startup_cnt + CW'(1);
            end
            if (startup_cnt == READY_AT) begin
                switch_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: directed plan steps plus random switch traffic
// compared every cycle against a sample-window reference model.
module tb_switch_debounce;

    localparam int W = 4;
    localparam int D = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] switch_raw;
    logic [W-1:0] switch_stable;
    logic [W-1:0] switch_changed;
    logic         switch_ready;

    switch_debounce #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clock(clock),
        .reset(reset),
        .switch_raw(switch_raw),
        .switch_stable(switch_stable),
        .switch_changed(switch_changed),
        .switch_ready(switch_ready)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    // Reference: a bit is accepted once the last D synchronised samples
    // seen since reset all disagree with the current stable value.
    logic [W-1:0] m_s1, m_s2;
    logic [W-1:0] m_stable, m_changed;
    logic         m_ready;
    int           m_edges;
    logic [W-1:0] hist[$];

    task automatic check(input string tag, input logic [W-1:0] obs,
                         input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [W-1:0] flip;
        logic         all;
        int           n;
        if (reset) begin
            m_s1 = '0;
            m_s2 = '0;
            m_stable = '0;
            m_changed = '0;
            m_ready = 1'b0;
            m_edges = 0;
            hist.delete();
        end else begin
            hist.push_back(m_s2);
            if (hist.size() > D) void'(hist.pop_front());
            m_s2 = m_s1;
            m_s1 = switch_raw;
            flip = '0;
            n = hist.size();
            if (n >= D) begin
                for (int i = 0; i < W; i++) begin
                    all = 1'b1;
                    for (int k = 0; k < D; k++)
                        if (hist[n-1-k][i] == m_stable[i]) all = 1'b0;
                    flip[i] = all;
                end
            end
            m_changed = flip & {W{m_ready}};
            m_stable = m_stable ^ flip;
            m_edges++;
            if (m_edges == D + 2) m_ready = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        check("stable", switch_stable, m_stable);
        check("changed", switch_changed, m_changed);
        check("ready", W'(switch_ready), W'(m_ready));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset = 1'b1;
        switch_raw = '0;
        m_s1 = '0;
        m_s2 = '0;
        m_stable = '0;
        m_changed = '0;
        m_ready = 1'b0;
        m_edges = 0;

        // Plan 1: quiet power-up
        ticks(3);
        check("p1_rst_stable", switch_stable, 4'b0000);
        check("p1_rst_ready", W'(switch_ready), 4'b0000);
        reset = 1'b0;
        ticks(5);
        check("p1_ready_e5", W'(switch_ready), 4'b0000);
        tick();
        check("p1_ready_e6", W'(switch_ready), 4'b0001);
        check("p1_stable", switch_stable, 4'b0000);
        ticks(2);

        // Plan 2: switches on during reset
        reset = 1'b1;
        switch_raw = 4'b1010;
        ticks(2);
        reset = 1'b0;
        ticks(5);
        check("p2_stable_e5", switch_stable, 4'b0000);
        tick();
        check("p2_stable_e6", switch_stable, 4'b1010);
        check("p2_ready_e6", W'(switch_ready), 4'b0001);
        check("p2_changed", switch_changed, 4'b0000);
        ticks(2);

        // Plan 3: single bit rise
        reset = 1'b1;
        switch_raw = '0;
        tick();
        reset = 1'b0;
        ticks(8);
        switch_raw = 4'b0001;
        ticks(5);
        check("p3_stable_e5", switch_stable, 4'b0000);
        tick();
        check("p3_stable_e6", switch_stable, 4'b0001);
        check("p3_pulse", switch_changed, 4'b0001);
        tick();
        check("p3_pulse_end", switch_changed, 4'b0000);

        // Plan 4: glitch on bit2 restarts the window
        switch_raw = 4'b0101;
        ticks(3);
        switch_raw = 4'b0001;
        tick();
        switch_raw = 4'b0101;
        ticks(5);
        check("p4_stable_e5", switch_stable, 4'b0001);
        tick();
        check("p4_stable_e6", switch_stable, 4'b0101);
        check("p4_pulse", switch_changed, 4'b0100);
        ticks(2);

        // Plan 5: all bits at once
        switch_raw = 4'b0000;
        ticks(8);
        switch_raw = 4'b1111;
        ticks(6);
        check("p5_stable", switch_stable, 4'b1111);
        check("p5_pulse", switch_changed, 4'b1111);
        tick();
        check("p5_pulse_end", switch_changed, 4'b0000);
        switch_raw = 4'b0000;
        ticks(8);

        // Plan 6: reset mid-debounce
        switch_raw = 4'b1000;
        ticks(4);
        reset = 1'b1;
        tick();
        check("p6_rst_stable", switch_stable, 4'b0000);
        check("p6_rst_ready", W'(switch_ready), 4'b0000);
        reset = 1'b0;
        ticks(5);
        check("p6_ready_e5", W'(switch_ready), 4'b0000);
        tick();
        check("p6_stable_e6", switch_stable, 4'b1000);
        check("p6_ready_e6", W'(switch_ready), 4'b0001);
        check("p6_changed", switch_changed, 4'b0000);

        // Random traffic: sparse bit flips, short pulses, rare resets
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0)
                switch_raw = switch_raw ^ W'(1 << $urandom_range(0, W - 1));
            if ($urandom_range(0, 39) == 0)
                switch_raw = W'($urandom);
            reset = ($urandom_range(0, 249) == 0);
            tick();
        end
        reset = 1'b0;
        ticks(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
